// File: rtl/tie_queue_fifo.sv
// Parametrised FIFO bridging a producer core's TIE output queue to a consumer core's TIE input queue.
// Show-ahead head output, registered status flags, synchronous flush and sticky error flags.
module tie_queue_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AF_LEVEL   = DEPTH - 1,
  parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  FLUSH,
  input  logic                  TIE_OPQ_PushReq,
  input  logic [DATA_WIDTH-1:0] TIE_OPQ,
  output logic                  TIE_OPQ_Full,
  output logic                  TIE_OPQ_AlmostFull,
  input  logic                  TIE_IPQ_PopReq,
  output logic [DATA_WIDTH-1:0] TIE_IPQ,
  output logic                  TIE_IPQ_Empty,
  output logic [CNT_W-1:0]      COUNT,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_next;
  logic                  push_ok;
  logic                  pop_ok;

  assign push_ok = TIE_OPQ_PushReq & ~TIE_OPQ_Full;
  assign pop_ok  = TIE_IPQ_PopReq & ~TIE_IPQ_Empty;

  always_comb begin
    count_next = COUNT;
    if (FLUSH) begin
      count_next = '0;
    end else if (push_ok && !pop_ok) begin
      count_next = COUNT + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_next = COUNT - CNT_W'(1);
    end
  end

  // Flags are registered from count_next so they never depend combinationally on inputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      COUNT              <= '0;
      TIE_OPQ_Full       <= 1'b0;
      TIE_IPQ_Empty      <= 1'b1;
      TIE_OPQ_AlmostFull <= 1'b0;
      OVERFLOW           <= 1'b0;
      UNDERFLOW          <= 1'b0;
    end else begin
      COUNT              <= count_next;
      TIE_OPQ_Full       <= (count_next == DEPTH_C);
      TIE_IPQ_Empty      <= (count_next == '0);
      TIE_OPQ_AlmostFull <= (count_next >= AF_C);
      if (FLUSH) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        OVERFLOW  <= 1'b0;
        UNDERFLOW <= 1'b0;
      end else begin
        if (push_ok) begin
          wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
        end
        if (pop_ok) begin
          rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
        end
        if (TIE_OPQ_PushReq && TIE_OPQ_Full) begin
          OVERFLOW <= 1'b1;
        end
        if (TIE_IPQ_PopReq && TIE_IPQ_Empty) begin
          UNDERFLOW <= 1'b1;
        end
      end
    end
  end

  // Storage is deliberately not reset; the write is also qualified by RST_N so no partial write lands.
  always_ff @(posedge CLK) begin
    if (RST_N && push_ok && !FLUSH) begin
      mem[wr_ptr] <= TIE_OPQ;
    end
  end

  assign TIE_IPQ = TIE_IPQ_Empty ? '0 : mem[rd_ptr];

endmodule

// File: doc/tie_queue_fifo.md
Name: tie_queue_fifo

Overview:
- Parametrised FIFO bridging one Xtensa core's TIE output queue (push side) to another core's TIE input queue (pop side).
- Successor to the fixed 32-bit single-depth queue used in the two-core cosim testbenches.
- Adds configurable width and depth, an occupancy count, an almost-full watermark, synchronous flush, and sticky overflow/underflow error flags for bench checking.

Parameters:
- DATA_WIDTH, 32, width of each queue entry.
- DEPTH, 4, number of entries. Must be 2 or more; does not need to be a power of two.
- AF_LEVEL, DEPTH-1, occupancy at or above which TIE_OPQ_AlmostFull asserts. Legal range 1..DEPTH.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- FLUSH  in  1  synchronous clear of the queue contents.
- TIE_OPQ_PushReq  in  1  push request from the producer core.
- TIE_OPQ  in  DATA_WIDTH  push data.
- TIE_OPQ_Full  out  1  queue full; push is not accepted.
- TIE_OPQ_AlmostFull  out  1  count >= AF_LEVEL.
- TIE_IPQ_PopReq  in  1  pop request from the consumer core.
- TIE_IPQ  out  DATA_WIDTH  head entry (show-ahead).
- TIE_IPQ_Empty  out  1  queue empty; TIE_IPQ is invalid.
- COUNT  out  CNT_W  current occupancy.
- OVERFLOW  out  1  sticky flag: a push was attempted while full.
- UNDERFLOW  out  1  sticky flag: a pop was attempted while empty.

Behaviour:
- Reset (RST_N=0, takes effect immediately):
  - wr_ptr = rd_ptr = 0, COUNT = 0.
  - TIE_OPQ_Full = 0, TIE_IPQ_Empty = 1, TIE_OPQ_AlmostFull = 0, OVERFLOW = UNDERFLOW = 0.
  - TIE_IPQ is driven to 0 while empty.
  - Storage array contents are not reset.
- Push acceptance: push_ok = TIE_OPQ_PushReq & ~TIE_OPQ_Full. On push_ok, TIE_OPQ is written at wr_ptr and wr_ptr advances.
- Pop acceptance: pop_ok = TIE_IPQ_PopReq & ~TIE_IPQ_Empty. On pop_ok, rd_ptr advances.
- Pointer wrap: each pointer goes DEPTH-1 -> 0 (explicit compare, not modulo-2^n).
- COUNT update each edge: +1 on push_ok only, -1 on pop_ok only, unchanged when both or neither occur.
- Full, Empty and AlmostFull are registered and derived from the next COUNT:
  - Full = (next COUNT == DEPTH).
  - Empty = (next COUNT == 0).
  - AlmostFull = (next COUNT >= AF_LEVEL).
  - All three are therefore valid in the cycle after the state change.
- Latency:
  - A pushed word is visible on TIE_IPQ, with Empty=0, in the cycle after the push edge.
  - Space freed by a pop is visible (Full=0) in the cycle after the pop edge.
- TIE_IPQ = mem[rd_ptr] (combinational read of the head) whenever Empty=0.
- Simultaneous events:
  - Full with push and pop in the same cycle: pop is accepted, push is rejected (Full blocks it) and OVERFLOW sets. COUNT goes DEPTH -> DEPTH-1.
  - Empty with push and pop in the same cycle: push is accepted, pop is rejected and UNDERFLOW sets. COUNT goes 0 -> 1.
  - Both accepted with 0 < COUNT < DEPTH: COUNT is unchanged and both pointers advance.
- Error flags:
  - OVERFLOW sets on (PushReq & Full); UNDERFLOW sets on (PopReq & Empty).
  - Both are cleared only by reset or FLUSH.
  - A rejected push never modifies storage.
- FLUSH (synchronous):
  - Pointers and COUNT go to 0, Empty=1, Full=0, and both error flags clear.
  - FLUSH overrides any same-cycle push or pop; data presented that cycle is discarded and the error flags stay clear.
- Reset asserted mid-transfer: all state returns to reset values immediately. No partial write is retained as valid.
- No combinational path from any input to Full, Empty, AlmostFull or COUNT.

Test Plan:
- Reset, then 4 pushes of 0xA0..0xA3 (DEPTH=4): Full=1 after the 4th edge, AlmostFull=1 after the 3rd, COUNT=4. Pops return 0xA0, 0xA1, 0xA2, 0xA3 in order, then Empty=1.
- Full queue, PushReq with 0xFF and PopReq in the same cycle: 0xA0 is popped, 0xFF is not stored, OVERFLOW=1, COUNT=3.
- Empty queue, PushReq with 0x55 and PopReq in the same cycle: UNDERFLOW=1, COUNT=1, and TIE_IPQ=0x55 on the next cycle.
- Wrap test with DEPTH=3: 10 interleaved push/pop pairs of values 1..10 preserve order across the pointer wrap; COUNT never exceeds 1.
- COUNT=2 with OVERFLOW=1, then FLUSH with a same-cycle push of 0x77: next cycle COUNT=0, Empty=1, OVERFLOW=0, and 0x77 is not stored.
- RST_N dropped mid-stream with COUNT=3: outputs take reset values with no CLK edge. After release, the first push of 0x11 is the first word popped.
